// File: rtl/soc_system_clk_pkg.sv
// Shared definitions for the clocking subsystem: supervisor state encoding,
// default parameter values and the shared-timer width helper.
package soc_system_clk_pkg;

    // Supervisor states
    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } pll_state_e;

    // Default parameter values
    localparam int unsigned DEF_NUM_CLOCKS            = 3;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES    = 1024;
    localparam int unsigned DEF_STAGGER_CYCLES        = 16;
    localparam int unsigned DEF_RELOCK_TIMEOUT_CYCLES = 65536;
    localparam int unsigned DEF_PLL_RST_PULSE         = 8;
    localparam int unsigned DEF_CNT_W                 = 8;

    // Width of one timer able to hold any of the four interval lengths
    function automatic int unsigned timer_width(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c,
                                                input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/soc_system_sync2.sv
// Two-flop synchroniser, parametrisable width, synchronous active-low reset.
// Ports:
//   clk_i  - destination clock
//   rst_ni - synchronous active-low reset (clears both stages)
//   d_i    - asynchronous input
//   q_o    - synchronised output
module soc_system_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two stages of metastability settling
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/soc_system_pll_reset_seq.sv
// PLL supervisor: pulses the PLL reset, debounces the synchronised lock,
// releases per-domain resets in a staggered order, retries on lock timeout
// and re-asserts every domain reset on lock loss.
// Ports:
//   refclk          - reference clock, all logic on its rising edge
//   rst_n           - synchronous active-low reset
//   pll_locked      - PLL lock, asynchronous to refclk
//   sw_relock_req   - single-cycle request for a full PLL re-reset
//   pll_rst         - active-high PLL reset (registered)
//   domain_rst_n    - per-domain active-low resets, bit 0 released first
//   all_ready       - every domain released and PLL locked
//   lock_loss_count - saturating count of debounced lock losses
//   retry_count     - saturating count of lock timeouts
module soc_system_pll_reset_seq
    import soc_system_clk_pkg::*;
#(
    parameter int unsigned NUM_CLOCKS            = DEF_NUM_CLOCKS,
    parameter int unsigned LOCK_STABLE_CYCLES    = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned STAGGER_CYCLES        = DEF_STAGGER_CYCLES,
    parameter int unsigned RELOCK_TIMEOUT_CYCLES = DEF_RELOCK_TIMEOUT_CYCLES,
    parameter int unsigned PLL_RST_PULSE         = DEF_PLL_RST_PULSE,
    parameter int unsigned CNT_W                 = DEF_CNT_W
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  sw_relock_req,
    output logic                  pll_rst,
    output logic [NUM_CLOCKS-1:0] domain_rst_n,
    output logic                  all_ready,
    output logic [CNT_W-1:0]      lock_loss_count,
    output logic [CNT_W-1:0]      retry_count
);

    localparam int unsigned TMR_W = timer_width(RELOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES,
                                                STAGGER_CYCLES, PLL_RST_PULSE);

    // Terminal timer values: each interval ends when the timer shows length-1
    localparam logic [TMR_W-1:0] PULSE_LAST   = TMR_W'(PLL_RST_PULSE - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(RELOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] STAGGER_LAST = TMR_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    pll_state_e            state_q, state_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [NUM_CLOCKS-1:0] dom_q, dom_d;
    logic                  pll_rst_q, pll_rst_d;
    logic                  ready_q, ready_d;
    logic [CNT_W-1:0]      loss_q, loss_d;
    logic [CNT_W-1:0]      retry_q, retry_d;
    logic                  lk;

    // Only consumer of the raw lock input
    soc_system_sync2 #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk_i  (refclk),
        .rst_ni (rst_n),
        .d_i    (pll_locked),
        .q_o    (lk)
    );

    // State and output registers
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q   <= PLL_RESET;
            timer_q   <= '0;
            dom_q     <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            loss_q    <= '0;
            retry_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            dom_q     <= dom_d;
            pll_rst_q <= pll_rst_d;
            ready_q   <= ready_d;
            loss_q    <= loss_d;
            retry_q   <= retry_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TMR_W'(1);
        dom_d   = dom_q;
        loss_d  = loss_q;
        retry_d = retry_q;

        case (state_q)
            PLL_RESET: begin
                dom_d = '0;
                if (timer_q == PULSE_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lk) begin
                    state_d = STABLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = PLL_RESET;
                    retry_d = (retry_q == CNT_MAX) ? retry_q : retry_q + CNT_W'(1);
                end
            end
            STABLE: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = RELEASE;
                    dom_d   = NUM_CLOCKS'(1);
                end
            end
            RELEASE: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                    dom_d   = '0;
                    loss_d  = (loss_q == CNT_MAX) ? loss_q : loss_q + CNT_W'(1);
                end else if (&dom_q) begin
                    state_d = RUN;
                end else if (timer_q == STAGGER_LAST) begin
                    // Thermometer shift: next domain out of reset, stagger restarts
                    dom_d   = NUM_CLOCKS'({dom_q, 1'b1});
                    timer_d = '0;
                end
            end
            RUN: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                    dom_d   = '0;
                    loss_d  = (loss_q == CNT_MAX) ? loss_q : loss_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = PLL_RESET;
                dom_d   = '0;
            end
        endcase

        // Software relock overrides everything except an in-progress pulse
        if (sw_relock_req && (state_q != PLL_RESET)) begin
            state_d = PLL_RESET;
            dom_d   = '0;
        end

        if (state_d != state_q) timer_d = '0;

        pll_rst_d = (state_d == PLL_RESET);
        ready_d   = (state_d == RUN);
    end

    assign pll_rst         = pll_rst_q;
    assign domain_rst_n    = dom_q;
    assign all_ready       = ready_q;
    assign lock_loss_count = loss_q;
    assign retry_count     = retry_q;

endmodule

// File: doc/soc_system_pll_reset_seq.md
Name: soc_system_pll_reset_seq

Overview:
Parametrised PLL supervisor for the next-generation clocking subsystem.
- Drives the PLL reset and monitors its asynchronous lock output.
- Debounces lock, then releases per-clock-domain resets in a staggered order.
- Retries the PLL on lock timeout, and re-asserts all domain resets on lock loss.
- Sits beside the PLL wrapper, in the refclk domain, and feeds the reset synchronisers of each outclk domain.

Parameters:
NUM_CLOCKS, 3, number of output clock domains (1..18).
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before release (>=1).
STAGGER_CYCLES, 16, cycles between successive domain reset releases (>=1).
RELOCK_TIMEOUT_CYCLES, 65536, cycles in WAIT_LOCK before a PLL reset retry (>=2).
PLL_RST_PULSE, 8, width of the pll_rst pulse in cycles (>=1).
CNT_W, 8, width of the saturating lock-loss and retry counters.

Ports:
refclk  in  1  reference clock; all logic is on its rising edge.
rst_n  in  1  reset, synchronous, active-low.
pll_locked  in  1  PLL lock, asynchronous to refclk.
sw_relock_req  in  1  single-cycle pulse; forces a full PLL re-reset.
pll_rst  out  1  active-high reset to the PLL.
domain_rst_n  out  NUM_CLOCKS  per-domain active-low resets; bit 0 is released first.
all_ready  out  1  high when every domain is out of reset and the PLL is locked.
lock_loss_count  out  CNT_W  saturating count of lock losses after debounce.
retry_count  out  CNT_W  saturating count of WAIT_LOCK timeouts.

Behaviour:
- Reset (rst_n=0 at an edge) forces the following values:
  - pll_rst=1, domain_rst_n=all 0s, all_ready=0.
  - Both counters = 0, synchroniser flops = 0, state = PLL_RESET with its timer at 0.
- pll_locked passes through a 2-flop synchroniser; lk denotes the synchroniser output. No other logic samples pll_locked.
- PLL_RESET:
  - pll_rst=1 for exactly PLL_RST_PULSE cycles, then go to WAIT_LOCK.
  - domain_rst_n is held all 0s.
- WAIT_LOCK:
  - pll_rst=0; a timer counts up.
  - lk=1: go to STABLE and clear the timer.
  - Timer reaches RELOCK_TIMEOUT_CYCLES-1 with lk=0: go to PLL_RESET and increment retry_count (saturating).
- STABLE:
  - Counts consecutive lk=1 cycles.
  - lk=0: return to WAIT_LOCK; no counter change.
  - Count reaches LOCK_STABLE_CYCLES: go to RELEASE.
- RELEASE:
  - On the entry edge, domain_rst_n[0]=1.
  - Every STAGGER_CYCLES thereafter, the next bit goes high; released bits stay high.
  - After bit NUM_CLOCKS-1 is released, go to RUN.
  - all_ready rises one cycle after the last release.
- RUN: all_ready=1, domain_rst_n all 1s.
- Lock loss (lk=0 in RELEASE or RUN):
  - On the next edge, domain_rst_n goes all 0s and all_ready=0.
  - lock_loss_count increments (saturating at 2^CNT_W-1) and the state goes to WAIT_LOCK.
- Latency: pll_locked rising (held) to domain_rst_n[0] rising is exactly LOCK_STABLE_CYCLES+3 refclk edges. Domain i rises at that point + i*STAGGER_CYCLES.
- sw_relock_req in any state except PLL_RESET:
  - Next edge: PLL_RESET, all domains in reset, all_ready=0.
  - Counters change only by the normal rules.
- Simultaneous sw_relock_req and lock loss in RELEASE/RUN: sw_relock_req selects PLL_RESET, and lock_loss_count still increments.
- sw_relock_req during PLL_RESET is ignored; the pulse timer does not restart.
- Reset mid-operation: the same cycle-exact values as power-on reset; in-flight timers are discarded.
- NUM_CLOCKS=1: RELEASE lasts one cycle.
- Every domain_rst_n bit and pll_rst is a flop output; outputs have no combinational path from inputs.
- Timer width: $clog2 of the largest of RELOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES, STAGGER_CYCLES, PLL_RST_PULSE, plus 1. One shared timer is cleared on every state change.

Decomposition:
- Shared package soc_system_clk_pkg holds:
  - the state enum (PLL_RESET, WAIT_LOCK, STABLE, RELEASE, RUN);
  - a timer-width function;
  - the default constants for the parameters.
- One sub-module, soc_system_sync2: a parametrisable-width 2-flop synchroniser with synchronous active-low reset. It is reused by the downstream per-domain reset synchronisers.

Test Plan:
Use parameters LOCK_STABLE_CYCLES=8, STAGGER_CYCLES=4, RELOCK_TIMEOUT_CYCLES=32, PLL_RST_PULSE=4, NUM_CLOCKS=3.
1. Reset release, then raise pll_locked at cycle 10 and hold it -> pll_rst high cycles 0..3; domain_rst_n bits rise at cycles 21, 25, 29; all_ready=1 at 30; counters 0.
2. pll_locked held low -> pll_rst re-pulses every 36 cycles; retry_count reads 1, 2, 3. Saturation is checked with CNT_W=2: the count stays at 3.
3. Lock glitch of 3 cycles inside STABLE -> no domain release, counters unchanged; debounce restarts, with release 11 cycles after the relock.
4. pll_locked drop in RUN -> all domain_rst_n=0 and all_ready=0 exactly 3 edges after the drop; lock_loss_count=1; normal re-release after relock.
5. sw_relock_req in the same cycle as lk falling in RUN -> state PLL_RESET, pll_rst=1 for 4 cycles, lock_loss_count=1.
6. rst_n pulled low for 1 cycle during RELEASE after domain 0 has been released -> all outputs at reset values on the next edge, sequence restarts from PLL_RESET.
